// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - scoreboard hazard, stall, flush and halt-drain controller
// Optional macro FWD_EN: use ALU_BUB/LD_BUB bubble counts (forwarding core); otherwise DEPTH-3.
module pipe_hazard_ctrl #(
   parameter int NREG    = 16,
   parameter int RW      = 4,
   parameter int DEPTH   = 5,
   parameter int ALU_BUB = 0,
   parameter int LD_BUB  = 1,
   parameter bit R0_ZERO = 1'b1,
   parameter int SCW     = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           id_valid,
   input  logic [RW-1:0]  id_rs,
   input  logic           id_rs_en,
   input  logic [RW-1:0]  id_rt,
   input  logic           id_rt_en,
   input  logic [RW-1:0]  id_rd,
   input  logic           id_wr_en,
   input  logic           id_is_load,
   input  logic           id_halt,
   input  logic           br_taken,
   input  logic           mem_busy,
   output logic           pipe_en,
   output logic           pc_wen,
   output logic           if_id_wen,
   output logic           if_id_flush,
   output logic           id_ex_bubble,
   output logic           hlt,
   output logic [SCW-1:0] stall_cnt
);

   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // Without forwarding a reader must wait until the writer has passed WB.
   localparam logic [CW-1:0] ALU_LOAD   = CW'(FWD ? ALU_BUB : DEPTH - 3);
   localparam logic [CW-1:0] LD_LOAD    = CW'(FWD ? LD_BUB : DEPTH - 3);
   localparam logic [CW-1:0] DRAIN_INIT = CW'(DEPTH - 2);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] drain_cnt;
   logic [CW-1:0] drain_nx;
   logic [CW-1:0] sb [NREG];
   logic          rs_pend;
   logic          rt_pend;
   logic          haz;
   logic          issue;
   logic          sb_wr;

   assign rs_pend = id_rs_en && (sb[id_rs] != '0);
   assign rt_pend = id_rt_en && (sb[id_rt] != '0);
   assign haz     = id_valid && (rs_pend || rt_pend);
   assign issue   = id_valid && !haz && !mem_busy && (state == S_RUN);
   assign sb_wr   = issue && id_wr_en && !(R0_ZERO && (id_rd == '0));

   // The newest writer overwrites any older pending count for its register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) sb[i] <= '0;
      end else if (!mem_busy) begin
         for (int i = 0; i < NREG; i++) begin
            if (sb_wr && (id_rd == RW'(i)))
               sb[i] <= id_is_load ? LD_LOAD : ALU_LOAD;
            else if (sb[i] != '0)
               sb[i] <= sb[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_RUN;
         drain_cnt <= '0;
      end else begin
         state     <= state_nx;
         drain_cnt <= drain_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      drain_nx     = drain_cnt;
      pipe_en      = 1'b1;
      pc_wen       = 1'b1;
      if_id_wen    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      hlt          = (state == S_HALTED);

      case (state)
         S_RUN: begin
            if (issue && id_halt) begin
               state_nx = S_DRAIN;
               drain_nx = DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            if (!mem_busy) begin
               drain_nx = drain_cnt - 1'b1;
               if (drain_cnt == CW'(1)) state_nx = S_HALTED;
            end
         end
         S_HALTED: begin
         end
         default: state_nx = S_RUN;
      endcase

      // mem_busy freezes everything; a held br_taken is honoured after release.
      if (mem_busy) begin
         pipe_en   = 1'b0;
         pc_wen    = 1'b0;
         if_id_wen = 1'b0;
      end else if (state != S_RUN) begin
         pc_wen       = 1'b0;
         if_id_wen    = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (haz) begin
         pc_wen       = 1'b0;
         if_id_wen    = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (br_taken && !(id_valid && id_halt)) begin
         if_id_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if ((state == S_RUN) && haz && !mem_busy && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard-queue bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   localparam int SCW = 3;
`ifdef FWD_EN
   localparam int ALU_B = 0;
   localparam int LD_B  = 1;
`else
   localparam int ALU_B = 2;
   localparam int LD_B  = 2;
`endif
   // {pipe_en, pc_wen, if_id_wen, if_id_flush, id_ex_bubble, hlt}
   localparam logic [5:0] RUN_O = 6'b111000;
   localparam logic [5:0] STL_O = 6'b100010;
   localparam logic [5:0] BSY_O = 6'b000000;
   localparam logic [5:0] FLS_O = 6'b111100;
   localparam logic [5:0] HLT_O = 6'b100011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           id_valid, id_rs_en, id_rt_en, id_wr_en, id_is_load, id_halt;
   logic [3:0]     id_rs, id_rt, id_rd;
   logic           br_taken, mem_busy;
   logic           pipe_en, pc_wen, if_id_wen, if_id_flush, id_ex_bubble, hlt;
   logic [SCW-1:0] stall_cnt;

   pipe_hazard_ctrl #(.SCW(SCW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_en(id_rs_en), .id_rt(id_rt), .id_rt_en(id_rt_en),
      .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
      .id_halt(id_halt), .br_taken(br_taken), .mem_busy(mem_busy),
      .pipe_en(pipe_en), .pc_wen(pc_wen), .if_id_wen(if_id_wen),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .hlt(hlt), .stall_cnt(stall_cnt)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         exp_stall = 0;
   logic [5:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {pipe_en, pc_wen, if_id_wen, if_id_flush, id_ex_bubble, hlt};
   endfunction

   task automatic cyc(input string tag, input logic v,
                      input logic [3:0] rs, input logic rs_e,
                      input logic [3:0] rt, input logic rt_e,
                      input logic [3:0] rd, input logic we, input logic ld,
                      input logic hl, input logic br, input logic busy,
                      input logic [5:0] exp);
      @(posedge clk);
      #1;
      id_valid = v;  id_rs = rs; id_rs_en = rs_e; id_rt = rt; id_rt_en = rt_e;
      id_rd = rd; id_wr_en = we; id_is_load = ld; id_halt = hl;
      br_taken = br; mem_busy = busy;
      exp_q.push_back(exp);
      @(negedge clk);
      if (exp_q.size() == 0) check({tag, "_qempty"}, 32'd1, 32'd0);
      else check(tag, {26'd0, outs()}, {26'd0, exp_q.pop_front()});
   endtask

   task automatic stall_cyc(input string tag, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic br);
      cyc(tag, 1, rs, 1, rt, 1, rd, 1, 0, 0, br, 0, STL_O);
      if (exp_stall < (1 << SCW) - 1) exp_stall++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O);
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 0; id_rs = 0; id_rs_en = 0; id_rt = 0; id_rt_en = 0;
      id_rd = 0; id_wr_en = 0; id_is_load = 0; id_halt = 0;
      br_taken = 0; mem_busy = 0;
      #1 rst = 1'b0;
      #2;
      check("reset_outs", {26'd0, outs()}, {26'd0, RUN_O});
      check("reset_stall", 32'(stall_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // ALU writer then dependent reader
      cyc("add_r3", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, RUN_O);
      for (int i = 0; i < ALU_B; i++) stall_cyc("sub_r3_stall", 3, 5, 4, 0);
      cyc("sub_r3_issue", 1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0, RUN_O);
      idle(3);
      check("stall_alu", 32'(stall_cnt), 32'(exp_stall));

      // load-use through the rt port
      cyc("lw_r2", 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, RUN_O);
      for (int i = 0; i < LD_B; i++) stall_cyc("add_r2_stall", 1, 2, 6, 0);
      cyc("add_r2_issue", 1, 1, 1, 2, 1, 6, 1, 0, 0, 0, 0, RUN_O);
      idle(3);
      check("stall_load", 32'(stall_cnt), 32'(exp_stall));

      // load-use with mem_busy freezing the bubble
      cyc("lw_r2b", 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, RUN_O);
      for (int i = 0; i < 3; i++) cyc("busy_freeze", 1, 2, 1, 1, 1, 6, 1, 0, 0, 0, 1, BSY_O);
      check("stall_busy_hold", 32'(stall_cnt), 32'(exp_stall));
      for (int i = 0; i < LD_B; i++) stall_cyc("busy_stall", 2, 1, 6, 0);
      cyc("busy_issue", 1, 2, 1, 1, 1, 6, 1, 0, 0, 0, 0, RUN_O);
      idle(3);
      check("stall_busy", 32'(stall_cnt), 32'(exp_stall));

      // branches: plain, across mem_busy, and behind a load-use hazard
      cyc("br_flush", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FLS_O);
      idle(1);
      cyc("br_busy", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BSY_O);
      cyc("br_after_busy", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FLS_O);
      cyc("lw_r7", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, RUN_O);
      for (int i = 0; i < LD_B; i++) stall_cyc("br_haz_stall", 7, 0, 0, 1);
      cyc("br_haz_flush", 1, 7, 1, 0, 1, 0, 0, 0, 0, 1, 0, FLS_O);
      idle(3);
      check("stall_br", 32'(stall_cnt), 32'(exp_stall));

      // register 0 is never scoreboarded
      cyc("wr_r0", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, RUN_O);
      cyc("rd_r0", 1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, RUN_O);
      idle(3);
      check("stall_r0", 32'(stall_cnt), 32'(exp_stall));

      // repeated load-use pairs drive the counter into saturation
      for (int k = 0; k < 8; k++) begin
         cyc("sat_lw", 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, RUN_O);
         for (int i = 0; i < LD_B; i++) stall_cyc("sat_stall", 9, 9, 10, 0);
         cyc("sat_issue", 1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, RUN_O);
         idle(3);
      end
      check("stall_sat", 32'(stall_cnt), 32'((1 << SCW) - 1));

      // HLT with a taken branch: halt wins, then drain (one busy cycle inside)
      cyc("hlt_issue", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, RUN_O);
      cyc("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL_O);
      cyc("drain_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, BSY_O);
      cyc("drain2", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, STL_O);
      cyc("drain3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL_O);
      cyc("halted1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLT_O);
      cyc("halted_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000001);
      cyc("halted2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, HLT_O);
      check("stall_drain", 32'(stall_cnt), 32'(exp_stall));

      // asynchronous reset mid-cycle
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_hlt", 32'(hlt), 32'd0);
      check("async_pc_wen", 32'(pc_wen), 32'd1);
      check("async_stall", 32'(stall_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      cyc("post_reset_add", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, RUN_O);
      cyc("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
